reg_file_param: RTL and testbench

//  Parametrised register file for the datapath: two combinational read ports, one write port.

---
 rtl/reg_file_pkg.sv | 18 +
 rtl/reg_file_pend_buf.sv | 80 ++++++++
 rtl/reg_file_param.sv | 85 ++++++++
 tb/tb_reg_file_param.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared types and default sizes for the register file slice.
// Optional feature macro: REG_FILE_BYPASS_EN (same-cycle forwarding of IN to the read ports).
package reg_file_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 3;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] data;
  } pend_t;

endpackage

// File: rtl/reg_file_pend_buf.sv
// One-entry pending write buffer with its IDLE/HOLD controller.
// Writes that arrive during a memory stall are parked here and retired
// to the array on the first non-stalled cycle.
module reg_file_pend_buf
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 0
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              WRITE,
  input  logic              BUSYWAIT,
  input  logic [ADDR_W-1:0] INADDRESS,
  input  logic [DATA_W-1:0] IN,
  output logic              pend_valid,
  output logic [ADDR_W-1:0] pend_addr,
  output logic [DATA_W-1:0] pend_data,
  output logic              retire
);

  state_t state;
  state_t state_nxt;
  logic   capture;
  logic   write_ok;

  assign write_ok   = WRITE && !((ZERO_REG != 0) && (INADDRESS == '0));
  assign pend_valid = (state == HOLD);

  // Next-state, capture and retire decisions; a release with a new write
  // retires the old entry and parks the new one in the same cycle.
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    retire    = 1'b0;
    case (state)
      IDLE: begin
        if (write_ok && BUSYWAIT) begin
          capture   = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (BUSYWAIT) begin
          capture = write_ok;
        end else begin
          retire = 1'b1;
          if (write_ok) begin
            capture = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register; reset discards any parked write.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Pending entry storage; the latest captured write wins.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      pend_addr <= '0;
      pend_data <= '0;
    end else if (capture) begin
      pend_addr <= INADDRESS;
      pend_data <= IN;
    end
  end

endmodule

// File: rtl/reg_file_param.sv
// Parametrised register file: two combinational read ports, one write port,
// with stalled writes parked in a one-entry pending buffer.
// Optional feature macro: REG_FILE_BYPASS_EN (forward IN to a read port
// addressing the register being written in the same cycle).
module reg_file_param
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 0
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic [DATA_W-1:0] IN,
  input  logic [ADDR_W-1:0] INADDRESS,
  input  logic              WRITE,
  input  logic              BUSYWAIT,
  input  logic [ADDR_W-1:0] OUT1ADDRESS,
  input  logic [ADDR_W-1:0] OUT2ADDRESS,
  output logic [DATA_W-1:0] OUT1,
  output logic [DATA_W-1:0] OUT2,
  output logic              PEND_VALID
);

  localparam int NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [NREGS];
  logic              pend_valid;
  logic [ADDR_W-1:0] pend_addr;
  logic [DATA_W-1:0] pend_data;
  logic              retire;
  logic              direct_we;

  reg_file_pend_buf #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .ZERO_REG(ZERO_REG)
  ) u_pend (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .WRITE     (WRITE),
    .BUSYWAIT  (BUSYWAIT),
    .INADDRESS (INADDRESS),
    .IN        (IN),
    .pend_valid(pend_valid),
    .pend_addr (pend_addr),
    .pend_data (pend_data),
    .retire    (retire)
  );

  // A write goes straight to the array only when nothing is stalled or parked;
  // otherwise the pending buffer owns it so array order is preserved.
  assign direct_we = WRITE && !BUSYWAIT && !pend_valid &&
                     !((ZERO_REG != 0) && (INADDRESS == '0));

  assign PEND_VALID = pend_valid;

  // Register array: at most one update per cycle, retire taking the slot.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (retire) begin
      regs[pend_addr] <= pend_data;
    end else if (direct_we) begin
      regs[INADDRESS] <= IN;
    end
  end

  // Read muxes: optional IN bypass over pending forward over array; register 0 forced when hardwired.
  always_comb begin
    OUT1 = regs[OUT1ADDRESS];
    OUT2 = regs[OUT2ADDRESS];
    if (pend_valid && (OUT1ADDRESS == pend_addr)) OUT1 = pend_data;
    if (pend_valid && (OUT2ADDRESS == pend_addr)) OUT2 = pend_data;
`ifdef REG_FILE_BYPASS_EN
    if (WRITE && (INADDRESS == OUT1ADDRESS)) OUT1 = IN;
    if (WRITE && (INADDRESS == OUT2ADDRESS)) OUT2 = IN;
`endif
    if ((ZERO_REG != 0) && (OUT1ADDRESS == '0)) OUT1 = '0;
    if ((ZERO_REG != 0) && (OUT2ADDRESS == '0)) OUT2 = '0;
  end

endmodule

// File: tb/tb_reg_file_param.sv
// Self-checking bench for reg_file_param (ZERO_REG=1 instance).
// Build with REG_FILE_BYPASS_EN defined to exercise same-cycle forwarding.
module tb_reg_file_param;

  logic       CLK = 1'b0;
  logic       RESET_N;
  logic [7:0] IN;
  logic [2:0] INADDRESS;
  logic       WRITE;
  logic       BUSYWAIT;
  logic [2:0] OUT1ADDRESS;
  logic [2:0] OUT2ADDRESS;
  logic [7:0] OUT1;
  logic [7:0] OUT2;
  logic       PEND_VALID;

  typedef struct {
    logic       port;
    logic [2:0] addr;
    logic [7:0] data;
    string      name;
  } expItem_t;

  expItem_t   scoreBoard[$];
  expItem_t   item;
  logic [7:0] observed;
  int         nChecks = 0;
  int         nFail   = 0;

  reg_file_param #(
    .DATA_W  (8),
    .ADDR_W  (3),
    .ZERO_REG(1)
  ) dut (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .IN         (IN),
    .INADDRESS  (INADDRESS),
    .WRITE      (WRITE),
    .BUSYWAIT   (BUSYWAIT),
    .OUT1ADDRESS(OUT1ADDRESS),
    .OUT2ADDRESS(OUT2ADDRESS),
    .OUT1       (OUT1),
    .OUT2       (OUT2),
    .PEND_VALID (PEND_VALID)
  );

  // Free-running clock, posedges at 5, 15, 25, ...
  always #5 CLK = ~CLK;

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, observed running expected finished");
    $fatal(1, "[TB] watchdog");
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RESET_N = 1'b0; WRITE = 1'b0; BUSYWAIT = 1'b0; IN = '0; INADDRESS = '0;
    OUT1ADDRESS = '0; OUT2ADDRESS = '0;
    #12;
    for (int a = 0; a < 8; a++) begin
      OUT1ADDRESS = a[2:0];
      #1;
      nChecks++;
      if (OUT1 !== 8'h00) begin
        nFail++;
        $display("[TB] FAIL reset_clear R%0d: observed %h expected 00", a, OUT1);
      end
    end
    nChecks++;
    if (PEND_VALID !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL reset_pend: observed %b expected 0", PEND_VALID);
    end
    RESET_N = 1'b1;
    cyc();
    WRITE = 1'b1; INADDRESS = 3'd3; IN = 8'h5A;
    cyc();
    WRITE = 1'b0; OUT1ADDRESS = 3'd3;
    #1;
    nChecks++;
    if (OUT1 !== 8'h5A) begin
      nFail++;
      $display("[TB] FAIL reset_prewrite R3: observed %h expected 5a", OUT1);
    end
    #1;
    RESET_N = 1'b0;
    #1;
    nChecks++;
    if (OUT1 !== 8'h00) begin
      nFail++;
      $display("[TB] FAIL reset_async R3: observed %h expected 00", OUT1);
    end
    nChecks++;
    if (PEND_VALID !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL reset_async_pend: observed %b expected 0", PEND_VALID);
    end
    RESET_N = 1'b1;
  endtask

  task automatic test_plain_write();
    cyc();
    WRITE = 1'b1; INADDRESS = 3'd5; IN = 8'hC3; BUSYWAIT = 1'b0; OUT2ADDRESS = 3'd5;
`ifndef REG_FILE_BYPASS_EN
    #1;
    nChecks++;
    if (OUT2 !== 8'h00) begin
      nFail++;
      $display("[TB] FAIL plain_before_edge R5: observed %h expected 00", OUT2);
    end
`endif
    scoreBoard.push_back('{1'b1, 3'd5, 8'hC3, "plain_write"});
    cyc();
    WRITE = 1'b0;
    #1;
    nChecks++;
    if (PEND_VALID !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL plain_pend: observed %b expected 0", PEND_VALID);
    end
    while (scoreBoard.size() > 0) begin
      item = scoreBoard.pop_front();
      OUT1ADDRESS = item.addr; OUT2ADDRESS = item.addr;
      @(negedge CLK);
      observed = item.port ? OUT2 : OUT1;
      nChecks++;
      if (observed !== item.data) begin
        nFail++;
        $display("[TB] FAIL %s port%0d R%0d: observed %h expected %h", item.name, item.port + 1, item.addr, observed, item.data);
      end
    end
  endtask

  task automatic test_stall();
    cyc();
    BUSYWAIT = 1'b1; WRITE = 1'b1; INADDRESS = 3'd2; IN = 8'h11; OUT1ADDRESS = 3'd2;
    cyc();
    WRITE = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      nChecks++;
      if (PEND_VALID !== 1'b1) begin
        nFail++;
        $display("[TB] FAIL stall_pend cycle%0d: observed %b expected 1", c, PEND_VALID);
      end
      nChecks++;
      if (OUT1 !== 8'h11) begin
        nFail++;
        $display("[TB] FAIL stall_forward cycle%0d R2: observed %h expected 11", c, OUT1);
      end
      if (c < 2) cyc();
    end
    BUSYWAIT = 1'b0;
    cyc();
    #1;
    nChecks++;
    if (PEND_VALID !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL stall_release_pend: observed %b expected 0", PEND_VALID);
    end
    nChecks++;
    if (OUT1 !== 8'h11) begin
      nFail++;
      $display("[TB] FAIL stall_retired R2: observed %h expected 11", OUT1);
    end
  endtask

  task automatic test_overwrite();
    cyc();
    BUSYWAIT = 1'b1; WRITE = 1'b1; INADDRESS = 3'd3; IN = 8'hAA;
    cyc();
    INADDRESS = 3'd7; IN = 8'hBB;
    cyc();
    WRITE = 1'b0; OUT1ADDRESS = 3'd7; OUT2ADDRESS = 3'd3;
    #1;
    nChecks++;
    if (OUT1 !== 8'hBB) begin
      nFail++;
      $display("[TB] FAIL overwrite_forward R7: observed %h expected bb", OUT1);
    end
    nChecks++;
    if (OUT2 !== 8'h00) begin
      nFail++;
      $display("[TB] FAIL overwrite_lost R3: observed %h expected 00", OUT2);
    end
    BUSYWAIT = 1'b0;
    scoreBoard.push_back('{1'b0, 3'd7, 8'hBB, "overwrite_retired"});
    scoreBoard.push_back('{1'b1, 3'd3, 8'h00, "overwrite_untouched"});
    cyc();
    while (scoreBoard.size() > 0) begin
      item = scoreBoard.pop_front();
      OUT1ADDRESS = item.addr; OUT2ADDRESS = item.addr;
      @(negedge CLK);
      observed = item.port ? OUT2 : OUT1;
      nChecks++;
      if (observed !== item.data) begin
        nFail++;
        $display("[TB] FAIL %s port%0d R%0d: observed %h expected %h", item.name, item.port + 1, item.addr, observed, item.data);
      end
    end
  endtask

  task automatic test_release_new();
    cyc();
    BUSYWAIT = 1'b1; WRITE = 1'b1; INADDRESS = 3'd1; IN = 8'h22;
    cyc();
    WRITE = 1'b0;
    cyc();
    BUSYWAIT = 1'b0; WRITE = 1'b1; INADDRESS = 3'd4; IN = 8'h33;
    cyc();
    WRITE = 1'b0; OUT1ADDRESS = 3'd1; OUT2ADDRESS = 3'd4;
    #1;
    nChecks++;
    if (PEND_VALID !== 1'b1) begin
      nFail++;
      $display("[TB] FAIL release_new_pend: observed %b expected 1", PEND_VALID);
    end
    nChecks++;
    if (OUT1 !== 8'h22) begin
      nFail++;
      $display("[TB] FAIL release_new_retired R1: observed %h expected 22", OUT1);
    end
    nChecks++;
    if (OUT2 !== 8'h33) begin
      nFail++;
      $display("[TB] FAIL release_new_forward R4: observed %h expected 33", OUT2);
    end
    cyc();
    #1;
    nChecks++;
    if (PEND_VALID !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL release_new_drain_pend: observed %b expected 0", PEND_VALID);
    end
    scoreBoard.push_back('{1'b1, 3'd4, 8'h33, "release_new_R4"});
    scoreBoard.push_back('{1'b0, 3'd1, 8'h22, "release_new_R1"});
    while (scoreBoard.size() > 0) begin
      item = scoreBoard.pop_front();
      OUT1ADDRESS = item.addr; OUT2ADDRESS = item.addr;
      @(negedge CLK);
      observed = item.port ? OUT2 : OUT1;
      nChecks++;
      if (observed !== item.data) begin
        nFail++;
        $display("[TB] FAIL %s port%0d R%0d: observed %h expected %h", item.name, item.port + 1, item.addr, observed, item.data);
      end
    end
  endtask

  task automatic test_reset_hold();
    cyc();
    BUSYWAIT = 1'b1; WRITE = 1'b1; INADDRESS = 3'd6; IN = 8'h77; OUT1ADDRESS = 3'd6;
    cyc();
    WRITE = 1'b0;
    #1;
    nChecks++;
    if (OUT1 !== 8'h77 || PEND_VALID !== 1'b1) begin
      nFail++;
      $display("[TB] FAIL reset_hold_parked R6: observed %h/%b expected 77/1", OUT1, PEND_VALID);
    end
    RESET_N = 1'b0;
    #1;
    nChecks++;
    if (OUT1 !== 8'h00 || PEND_VALID !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL reset_hold_clear R6: observed %h/%b expected 00/0", OUT1, PEND_VALID);
    end
    RESET_N = 1'b1; BUSYWAIT = 1'b0;
    cyc();
    cyc();
    nChecks++;
    if (OUT1 !== 8'h00 || PEND_VALID !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL reset_hold_no_retire R6: observed %h/%b expected 00/0", OUT1, PEND_VALID);
    end
  endtask

  task automatic test_zero_reg();
    cyc();
    WRITE = 1'b1; INADDRESS = 3'd0; IN = 8'hFF; BUSYWAIT = 1'b0; OUT1ADDRESS = 3'd0;
    #1;
    nChecks++;
    if (OUT1 !== 8'h00) begin
      nFail++;
      $display("[TB] FAIL zero_same_cycle R0: observed %h expected 00", OUT1);
    end
    cyc();
    BUSYWAIT = 1'b1;
    scoreBoard.push_back('{1'b0, 3'd0, 8'h00, "zero_after_write"});
    cyc();
    WRITE = 1'b0;
    #1;
    nChecks++;
    if (PEND_VALID !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL zero_never_parked: observed %b expected 0", PEND_VALID);
    end
    BUSYWAIT = 1'b0;
    while (scoreBoard.size() > 0) begin
      item = scoreBoard.pop_front();
      OUT1ADDRESS = item.addr; OUT2ADDRESS = item.addr;
      @(negedge CLK);
      observed = item.port ? OUT2 : OUT1;
      nChecks++;
      if (observed !== item.data) begin
        nFail++;
        $display("[TB] FAIL %s port%0d R%0d: observed %h expected %h", item.name, item.port + 1, item.addr, observed, item.data);
      end
    end
    cyc();
    WRITE = 1'b1; INADDRESS = 3'd7; IN = 8'h9E; OUT1ADDRESS = 3'd7;
    #1;
    nChecks++;
`ifdef REG_FILE_BYPASS_EN
    if (OUT1 !== 8'h9E) begin
      nFail++;
      $display("[TB] FAIL bypass_same_cycle R7: observed %h expected 9e", OUT1);
    end
`else
    if (OUT1 !== 8'h00) begin
      nFail++;
      $display("[TB] FAIL no_bypass_same_cycle R7: observed %h expected 00", OUT1);
    end
`endif
    cyc();
    WRITE = 1'b0;
    #1;
    nChecks++;
    if (OUT1 !== 8'h9E) begin
      nFail++;
      $display("[TB] FAIL zero_test_next_cycle R7: observed %h expected 9e", OUT1);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d;
    cyc();
    for (int a = 1; a < 8; a++) begin
      d = 8'($urandom_range(0, 255));
      WRITE = 1'b1; INADDRESS = a[2:0]; IN = d; BUSYWAIT = 1'b0;
      scoreBoard.push_back('{a[0], a[2:0], d, "back_to_back"});
      cyc();
    end
    WRITE = 1'b0;
    while (scoreBoard.size() > 0) begin
      item = scoreBoard.pop_front();
      OUT1ADDRESS = item.addr; OUT2ADDRESS = item.addr;
      @(negedge CLK);
      observed = item.port ? OUT2 : OUT1;
      nChecks++;
      if (observed !== item.data) begin
        nFail++;
        $display("[TB] FAIL %s port%0d R%0d: observed %h expected %h", item.name, item.port + 1, item.addr, observed, item.data);
      end
    end
  endtask

  // Test sequence.
  initial begin
    test_reset();
    test_plain_write();
    test_stall();
    test_overwrite();
    test_release_new();
    test_reset_hold();
    test_zero_reg();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
